cpu_multicycle_ctrl: RTL and testbench
======================================

Name: cpu_multicycle_ctrl

Overview:
Parametrised multi-cycle control unit for the next-generation 16-bit CPU. It replaces the single-cycle decode with a Moore/Mealy FSM that sequences each instruction over several cycles. It shares one memory port through a req/ready handshake and adds HALT, illegal-opcode trap and memory-timeout detection. It sits between the instruction register (opcode, ALU zero flag) and the datapath muxes and enables.

Parameters:
OPCODE_W, 4, opcode field width; values above 4'hF are unused
MEM_TIMEOUT, 15, maximum cycles waiting for mem_ready before trap; 0 disables the timeout
ALUOP_W, 2, width of ALUOp

Ports:
Clock  in  1  system clock, rising edge
Resetn  in  1  asynchronous active-low reset
opcode  in  OPCODE_W  IR opcode field, stable from DECODE onward
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the access this cycle
mem_req  out  1  memory access request
mem_we  out  1  write access when mem_req=1
IorD  out  1  0=PC address, 1=ALUOut address
IRWrite  out  1  load IR
PCWrite  out  1  load PC
PCSource  out  2  00=ALU(PC+1), 01=ALUOut(branch), 10=jump target
RegDst  out  1  1=rd, 0=rt
ALUSrcA  out  1  0=PC, 1=regA
ALUSrcB  out  2  00=regB, 01=const 1, 10=sign-ext imm, 11=imm (branch offset)
ALUOp  out  ALUOP_W  00=add, 01=sub, 10=funct
MemToReg  out  1  write-back source is MDR
RegWrite  out  1  register file write
halted  out  1  sticky, core is stopped by HALT
illegal  out  1  sticky, illegal opcode trap
mem_err  out  1  sticky, memory timeout trap
state  out  4  current state encoding, for debug

Behaviour:
- Opcode map: 0=R-type, 1=ADDI, 2=LW, 3=SW, 4=BEQ, 5=BNE, 6=JMP, 15=HALT. All other values are illegal.
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, MEM_ADDR=5, MEM_RD=6, MEM_WR=7, WB_R=8, WB_MEM=9, BRANCH=10, JUMP=11, HALT=12, TRAP=13.
- Reset (async, Resetn=0):
  - state=IDLE.
  - Every output is 0, including the sticky flags and the timeout counter.
  - IDLE lasts exactly one cycle after Resetn deasserts, then the FSM enters FETCH.
- FETCH:
  - mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - When mem_ready=1 in the same cycle: IRWrite=1, PCWrite=1, next state DECODE. Otherwise the FSM stays in FETCH.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute).
  - Next state by opcode: 0→EXEC_R, 1→EXEC_I, 2/3→MEM_ADDR, 4/5→BRANCH, 6→JUMP, 15→HALT, else→TRAP with illegal=1.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next WB_R.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next WB_R.
- WB_R:
  - RegWrite=1, MemToReg=0.
  - RegDst=1 for R-type, 0 for ADDI.
  - Next FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_req=1, mem_we=0, IorD=1. On mem_ready go to WB_MEM; otherwise hold.
- MEM_WR: mem_req=1, mem_we=1, IorD=1. On mem_ready go to FETCH; otherwise hold.
- WB_MEM: RegWrite=1, MemToReg=1, RegDst=0; next FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01.
  - PCWrite = (opcode==4 & zero) | (opcode==5 & ~zero).
  - Next FETCH.
- JUMP: PCSource=10, PCWrite=1; next FETCH.
- HALT and TRAP are absorbing until reset. All enables are 0; halted or illegal/mem_err stay at 1.
- Cycle counts with zero-wait memory (mem_ready=1 on the first request cycle):
  - R/ADDI: 4
  - LW: 5
  - SW: 4
  - BEQ/BNE: 3
  - JMP: 3
  - Each wait cycle adds 1.
- Handshake rules:
  - mem_req and mem_we/IorD stay constant while waiting.
  - mem_ready is ignored when mem_req=0.
  - A single-cycle mem_ready completes the access.
- Timeout:
  - Counter clears on entry to each memory state and increments for each cycle with mem_req=1 & mem_ready=0.
  - If the count reaches MEM_TIMEOUT (when MEM_TIMEOUT≠0), the FSM goes to TRAP with mem_err=1 on the next edge.
  - mem_ready arriving on the same cycle the count reaches MEM_TIMEOUT wins: the access completes and there is no trap.
- Reset mid-access: the FSM returns to IDLE immediately and drops mem_req asynchronously.

Optional Feature:
Macro: CPU_PERF_CNT_EN.
- Defined:
  - Adds output instr_retired [31:0] and output cycle_count [31:0], both reset to 0.
  - cycle_count increments every cycle outside IDLE/HALT/TRAP.
  - instr_retired increments on each transition into FETCH from an execute/writeback state (WB_R, WB_MEM, MEM_WR, BRANCH, JUMP).
  - Both counters wrap at 2^32.
- Undefined: neither port nor either counter exists.

Test Plan:
- Reset, then R-type with mem_ready tied 1 → states 0,1,2,3,8,1; RegWrite=1 only in WB_R with RegDst=1; 4 cycles per instruction.
- LW with mem_ready delayed 3 cycles in MEM_RD → mem_req=1,IorD=1,mem_we=0 held 4 cycles; WB_MEM RegWrite=1,MemToReg=1; total 8 cycles.
- BEQ with zero=1, then BNE with zero=1 → PCWrite=1,PCSource=01 for the first; PCWrite=0 for the second.
- Opcode 4'h9 → TRAP; illegal=1 sticky and no further mem_req. Opcode 4'hF → halted=1.
- mem_ready never asserted in FETCH, MEM_TIMEOUT=15 → after 15 wait cycles state=TRAP, mem_err=1. Repeat with mem_ready on the 15th cycle → no trap.
- Resetn pulsed low mid-MEM_WR → mem_req drops without waiting for a clock edge, all flags clear, FETCH follows 1 cycle after release. With CPU_PERF_CNT_EN, instr_retired=0 after reset and 3 after three JMPs.

Source files
------------

// File: rtl/cpu_multicycle_ctrl.sv
// cpu_multicycle_ctrl: multi-cycle control FSM for the 16-bit CPU.
// Sequences each instruction over FETCH/DECODE/EXEC/MEM/WB states.
// A single memory port is shared through a req/ready handshake.
// HALT, the illegal-opcode trap and the memory-timeout trap are sticky until reset.
//
// Ports:
//   Clock, Resetn            rising-edge clock, async active-low reset
//   opcode, zero             IR opcode field and ALU zero flag
//   mem_ready                memory completes the pending access this cycle
//   mem_req, mem_we, IorD    memory request, write enable, address select
//   IRWrite, PCWrite         IR / PC load enables (combinational: depend on mem_ready / zero)
//   PCSource, RegDst, ALUSrcA, ALUSrcB, ALUOp, MemToReg, RegWrite   datapath controls
//   halted, illegal, mem_err sticky status flags
//   state                    current state encoding, for debug
//   instr_retired, cycle_count   performance counters (only with CPU_PERF_CNT_EN)
//
// Optional feature macro: CPU_PERF_CNT_EN.
// Assumes OPCODE_W >= 4. MEM_TIMEOUT = 0 disables the memory timeout.
module cpu_multicycle_ctrl #(
  parameter int unsigned OPCODE_W    = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned ALUOP_W     = 2
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                IorD,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic [1:0]          PCSource,
  output logic                RegDst,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                MemToReg,
  output logic                RegWrite,
  output logic                halted,
  output logic                illegal,
  output logic                mem_err,
  output logic [3:0]          state
`ifdef CPU_PERF_CNT_EN
  ,
  output logic [31:0]         instr_retired,
  output logic [31:0]         cycle_count
`endif
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit          TO_EN = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(MEM_TIMEOUT - 1) : '0;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(15);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_R     = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  state_t             state_q, next_state;
  logic [CNT_W-1:0]   wait_cnt_q;
  logic               in_mem_c, timeout_c;

  logic               mem_req_d, mem_we_d, IorD_d, RegDst_d, ALUSrcA_d;
  logic               MemToReg_d, RegWrite_d;
  logic [1:0]         PCSource_d, ALUSrcB_d;
  logic [ALUOP_W-1:0] ALUOp_d;

  // Next-state logic plus decode of the registered Moore outputs from the next state
  always_comb begin
    next_state = state_q;
    in_mem_c   = state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR};
    // ready in the final allowed cycle still completes the access
    timeout_c  = TO_EN && in_mem_c && !mem_ready && (wait_cnt_q == CNT_LAST);

    case (state_q)
      S_IDLE:     next_state = S_FETCH;
      S_FETCH:    if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:           next_state = S_EXEC_R;
          OP_ADDI:        next_state = S_EXEC_I;
          OP_LW, OP_SW:   next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE: next_state = S_BRANCH;
          OP_JMP:         next_state = S_JUMP;
          OP_HALT:        next_state = S_HALT;
          default:        next_state = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I: next_state = S_WB_R;
      S_MEM_ADDR: next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) next_state = S_WB_MEM;
      S_MEM_WR:   if (mem_ready) next_state = S_FETCH;
      S_WB_R, S_WB_MEM, S_BRANCH, S_JUMP: next_state = S_FETCH;
      S_HALT:     next_state = S_HALT;
      S_TRAP:     next_state = S_TRAP;
      default:    next_state = S_IDLE;
    endcase
    if (timeout_c) next_state = S_TRAP;

    mem_req_d  = next_state inside {S_FETCH, S_MEM_RD, S_MEM_WR};
    mem_we_d   = (next_state == S_MEM_WR);
    IorD_d     = next_state inside {S_MEM_RD, S_MEM_WR};
    RegDst_d   = (next_state == S_WB_R) && (opcode == OP_R);
    ALUSrcA_d  = next_state inside {S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_BRANCH};
    MemToReg_d = (next_state == S_WB_MEM);
    RegWrite_d = next_state inside {S_WB_R, S_WB_MEM};

    PCSource_d = 2'b00;
    if (next_state == S_BRANCH) PCSource_d = 2'b01;
    if (next_state == S_JUMP)   PCSource_d = 2'b10;

    ALUSrcB_d = 2'b00;
    case (next_state)
      S_FETCH:              ALUSrcB_d = 2'b01;
      S_DECODE:             ALUSrcB_d = 2'b11;
      S_EXEC_I, S_MEM_ADDR: ALUSrcB_d = 2'b10;
      default:              ALUSrcB_d = 2'b00;
    endcase

    ALUOp_d = '0;
    if (next_state == S_EXEC_R) ALUOp_d = ALUOP_W'(2'b10);
    if (next_state == S_BRANCH) ALUOp_d = ALUOP_W'(2'b01);
  end

  // State register and memory wait counter
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q <= next_state;
      if (next_state != state_q)
        wait_cnt_q <= '0;
      else if (TO_EN && in_mem_c && !mem_ready)
        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    end
  end

  // Registered datapath controls and sticky status flags
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      IorD     <= 1'b0;
      PCSource <= 2'b00;
      RegDst   <= 1'b0;
      ALUSrcA  <= 1'b0;
      ALUSrcB  <= 2'b00;
      ALUOp    <= '0;
      MemToReg <= 1'b0;
      RegWrite <= 1'b0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      mem_req  <= mem_req_d;
      mem_we   <= mem_we_d;
      IorD     <= IorD_d;
      PCSource <= PCSource_d;
      RegDst   <= RegDst_d;
      ALUSrcA  <= ALUSrcA_d;
      ALUSrcB  <= ALUSrcB_d;
      ALUOp    <= ALUOp_d;
      MemToReg <= MemToReg_d;
      RegWrite <= RegWrite_d;
      halted   <= halted | (next_state == S_HALT);
      illegal  <= illegal | ((state_q == S_DECODE) && (next_state == S_TRAP));
      mem_err  <= mem_err | timeout_c;
    end
  end

  // Load enables that must react to mem_ready / zero within the same cycle
  assign IRWrite = (state_q == S_FETCH) && mem_ready;
  assign PCWrite = ((state_q == S_FETCH) && mem_ready) ||
                   (state_q == S_JUMP) ||
                   ((state_q == S_BRANCH) &&
                    (((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero)));

  assign state = state_q;

`ifdef CPU_PERF_CNT_EN
  // Active-cycle and retired-instruction counters, free-running with wrap
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      instr_retired <= '0;
      cycle_count   <= '0;
    end else begin
      if (!(state_q inside {S_IDLE, S_HALT, S_TRAP}))
        cycle_count <= cycle_count + 32'd1;
      if ((next_state == S_FETCH) &&
          (state_q inside {S_WB_R, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP}))
        instr_retired <= instr_retired + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_multicycle_ctrl.sv
// Self-checking bench for cpu_multicycle_ctrl: per-instruction cycle plans
// built from the instruction phase rules, random waits/opcodes/flags.
module tb_cpu_multicycle_ctrl;

  localparam int TO = 15;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC_R = 3, S_EXEC_I = 4;
  localparam int S_MEM_ADDR = 5, S_MEM_RD = 6, S_MEM_WR = 7, S_WB_R = 8, S_WB_MEM = 9;
  localparam int S_BRANCH = 10, S_JUMP = 11, S_HALT = 12, S_TRAP = 13;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, IorD, IRWrite, PCWrite, RegDst, ALUSrcA;
  logic       MemToReg, RegWrite, halted, illegal, mem_err;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic [3:0] state;
`ifdef CPU_PERF_CNT_EN
  logic [31:0] instr_retired, cycle_count;
`endif

  cpu_multicycle_ctrl #(.OPCODE_W(4), .MEM_TIMEOUT(TO), .ALUOP_W(2)) dut (
    .Clock(Clock), .Resetn(Resetn), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSource(PCSource), .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .MemToReg(MemToReg), .RegWrite(RegWrite), .halted(halted),
    .illegal(illegal), .mem_err(mem_err), .state(state)
`ifdef CPU_PERF_CNT_EN
    , .instr_retired(instr_retired), .cycle_count(cycle_count)
`endif
  );

  always #5 Clock = ~Clock;

  logic [21:0] got;
  assign got = {mem_req, mem_we, IorD, IRWrite, PCWrite, PCSource, RegDst, ALUSrcA,
                ALUSrcB, ALUOp, MemToReg, RegWrite, halted, illegal, mem_err, state};

  int checks = 0;
  int errors = 0;

  // Model of the sticky flags
  logic m_halted, m_illegal, m_mem_err;

  // One planned cycle: state, whether mem_ready is meaningful, its value, flag to raise
  typedef struct {
    int st;
    bit care;
    bit rdy;
    int flag;
  } cyc_t;
  cyc_t plan[$];

  // Expected output vector for one cycle from the per-state control table
  function automatic logic [21:0] expv(input int st, input logic [3:0] op, input logic z,
                                       input logic rdy);
    logic mreq = 0, mwe = 0, iord = 0, irw = 0, pcw = 0, rdst = 0, asa = 0, m2r = 0, rw = 0;
    logic [1:0] pcs = 0, asb = 0, aop = 0;
    case (st)
      S_FETCH:    begin mreq = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      S_DECODE:   asb = 2'b11;
      S_EXEC_R:   begin asa = 1; aop = 2'b10; end
      S_EXEC_I:   begin asa = 1; asb = 2'b10; end
      S_MEM_ADDR: begin asa = 1; asb = 2'b10; end
      S_MEM_RD:   begin mreq = 1; iord = 1; end
      S_MEM_WR:   begin mreq = 1; mwe = 1; iord = 1; end
      S_WB_R:     begin rw = 1; rdst = (op == 4'd0); end
      S_WB_MEM:   begin rw = 1; m2r = 1; end
      S_BRANCH: begin
        asa = 1; aop = 2'b01; pcs = 2'b01;
        pcw = (op == 4'd4 && z) || (op == 4'd5 && !z);
      end
      S_JUMP:     begin pcs = 2'b10; pcw = 1; end
      default:    ;
    endcase
    return {mreq, mwe, iord, irw, pcw, pcs, rdst, asa, asb, aop, m2r, rw,
            m_halted, m_illegal, m_mem_err, 4'(st)};
  endfunction

  task automatic push(input int st, input bit care, input bit rdy, input int flag);
    cyc_t c;
    c.st = st; c.care = care; c.rdy = rdy; c.flag = flag;
    plan.push_back(c);
  endtask

  // Memory phase: waits idle cycles then ready, or a timeout trap
  task automatic plan_mem(input int st, input int waits, output bit to);
    if (waits >= TO) begin
      for (int k = 0; k < TO; k++) push(st, 1, 0, 0);
      push(S_TRAP, 0, 0, 3);
      to = 1;
    end else begin
      for (int k = 0; k < waits; k++) push(st, 1, 0, 0);
      push(st, 1, 1, 0);
      to = 0;
    end
  endtask

  task automatic build_plan(input logic [3:0] op, input int fw, input int mw);
    bit to;
    plan.delete();
    plan_mem(S_FETCH, fw, to);
    if (!to) begin
      push(S_DECODE, 0, 0, 0);
      case (op)
        4'd0: begin push(S_EXEC_R, 0, 0, 0); push(S_WB_R, 0, 0, 0); end
        4'd1: begin push(S_EXEC_I, 0, 0, 0); push(S_WB_R, 0, 0, 0); end
        4'd2: begin
          push(S_MEM_ADDR, 0, 0, 0);
          plan_mem(S_MEM_RD, mw, to);
          if (!to) push(S_WB_MEM, 0, 0, 0);
        end
        4'd3: begin push(S_MEM_ADDR, 0, 0, 0); plan_mem(S_MEM_WR, mw, to); end
        4'd4, 4'd5: push(S_BRANCH, 0, 0, 0);
        4'd6: push(S_JUMP, 0, 0, 0);
        4'd15: push(S_HALT, 0, 0, 1);
        default: push(S_TRAP, 0, 0, 2);
      endcase
    end
    // Terminal states are absorbing: keep observing them with random inputs
    if (plan[plan.size()-1].st == S_HALT || plan[plan.size()-1].st == S_TRAP)
      for (int k = 0; k < 3; k++) push(plan[plan.size()-1].st, 0, 0, 0);
  endtask

  // Drive the planned cycles (ncyc < 0: all) and compare every cycle
  task automatic run_plan(input string name, input logic [3:0] op, input logic z,
                          input int ncyc);
    logic [21:0] e;
    for (int i = 0; i < plan.size() && (ncyc < 0 || i < ncyc); i++) begin
      @(negedge Clock);
      opcode    = (plan[i].st == S_FETCH) ? 4'($urandom) : op;
      zero      = (plan[i].st == S_BRANCH) ? z : 1'($urandom);
      mem_ready = plan[i].care ? plan[i].rdy : 1'($urandom);
      case (plan[i].flag)
        1: m_halted = 1;
        2: m_illegal = 1;
        3: m_mem_err = 1;
        default: ;
      endcase
      #1;
      e = expv(plan[i].st, op, zero, mem_ready);
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s cycle %0d op %0d: got %h expected %h", name, i, op, got, e);
      end
    end
  endtask

  task automatic do_instr(input string name, input logic [3:0] op, input int fw,
                          input int mw, input logic z);
    build_plan(op, fw, mw);
    run_plan(name, op, z, -1);
  endtask

  task automatic do_reset(input string name);
    @(negedge Clock);
    Resetn = 0; mem_ready = 1; opcode = 4'($urandom);
    m_halted = 0; m_illegal = 0; m_mem_err = 0;
    #1;
    checks++;
    if (got !== 22'h0) begin
      errors++; $display("FAIL %s in_reset: got %h expected 000000", name, got);
    end
    @(negedge Clock);
    Resetn = 1; mem_ready = 1'($urandom);
    #1;
    checks++;
    if (got !== 22'h0) begin
      errors++; $display("FAIL %s idle_after_release: got %h expected 000000", name, got);
    end
  endtask

  task automatic test_reset();
    do_reset("reset");
  endtask

  task automatic test_rtype();
    do_reset("rtype_rst");
    do_instr("rtype0", 4'd0, 0, 0, 0);
    do_instr("rtype1", 4'd0, 0, 0, 0);
    do_instr("addi", 4'd1, 0, 0, 0);
  endtask

  task automatic test_lw_wait();
    do_instr("lw_wait3", 4'd2, 0, 3, 0);
    do_instr("sw_wait2", 4'd3, 2, 2, 0);
  endtask

  task automatic test_branch();
    do_instr("beq_z1", 4'd4, 0, 0, 1);
    do_instr("bne_z1", 4'd5, 0, 0, 1);
    do_instr("beq_z0", 4'd4, 1, 0, 0);
    do_instr("bne_z0", 4'd5, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 6));
      do_instr("random", op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end
  endtask

  task automatic test_illegal_halt();
    do_reset("illegal_rst");
    do_instr("illegal9", 4'd9, 0, 0, 0);
    do_reset("halt_rst");
    do_instr("halt", 4'd15, 1, 0, 0);
  endtask

  task automatic test_timeout();
    do_reset("to_rst");
    do_instr("fetch_timeout", 4'd0, TO, 0, 0);
    do_reset("to_rst2");
    do_instr("fetch_ready_last", 4'd0, TO - 1, 0, 0);
    do_instr("lw_ready_last", 4'd2, 0, TO - 1, 0);
    do_instr("lw_timeout", 4'd2, 0, TO + 3, 0);
  endtask

  task automatic test_reset_mid();
    do_reset("mid_rst");
    build_plan(4'd3, 0, 6);
    run_plan("mid_sw", 4'd3, 0, 5);
    #2;
    Resetn = 0;
    m_halted = 0; m_illegal = 0; m_mem_err = 0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || got !== 22'h0) begin
      errors++; $display("FAIL mid_async_drop: got %h expected 000000", got);
    end
    @(negedge Clock);
    @(negedge Clock);
    Resetn = 1;
    #1;
    checks++;
    if (got !== 22'h0) begin
      errors++; $display("FAIL mid_idle: got %h expected 000000", got);
    end
    do_instr("after_mid", 4'd0, 0, 0, 0);
  endtask

`ifdef CPU_PERF_CNT_EN
  task automatic test_perf();
    do_reset("perf_rst");
    checks++;
    if (instr_retired !== 32'd0 || cycle_count !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset: got %0d/%0d expected 0/0", instr_retired, cycle_count);
    end
    for (int n = 0; n < 3; n++) do_instr("perf_jmp", 4'd6, 0, 0, 0);
    @(negedge Clock);
    #1;
    checks++;
    if (instr_retired !== 32'd3 || cycle_count !== 32'd9) begin
      errors++;
      $display("FAIL perf_3jmp: got %0d/%0d expected 3/9", instr_retired, cycle_count);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_halted = 0; m_illegal = 0; m_mem_err = 0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch();
    test_random();
    test_illegal_halt();
    test_timeout();
    test_reset_mid();
`ifdef CPU_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
